// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported memory bus between the instruction
//                fetch port and the data-access port. MEM has priority unless
//                IF has been passed over MEM_BURST_MAX times in a row. Every
//                bus transaction ends in a one-cycle ack, with an error flag
//                if the bus does not respond within TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MEM_BURST_MAX = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic                  clk_i,
    input  logic                  rst,
    // instruction fetch port
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_ack,
    output logic                  if_err,
    output logic [DATA_W-1:0]     if_rdata,
    // data access port
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W/8-1:0]   mem_wstrb,
    output logic                  mem_ack,
    output logic                  mem_err,
    output logic [DATA_W-1:0]     mem_rdata,
    // shared memory bus
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_ack,
    // pipeline status
    output logic                  stall_o,
    output logic                  busy_o
);

    localparam int              BC_W        = $clog2(MEM_BURST_MAX + 1);
    localparam logic [BC_W-1:0] c_BURST_MAX = BC_W'(MEM_BURST_MAX);
    localparam logic [15:0]     c_TO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_IF  = 2'd1,
        BUS_MEM = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e                 state_q;
    logic [BC_W-1:0]        burst_cnt_q;
    logic [15:0]            to_cnt_q;
    logic                   busy_q;
    logic                   bus_req_q;
    logic                   bus_we_q;
    logic [ADDR_W-1:0]      bus_addr_q;
    logic [DATA_W-1:0]      bus_wdata_q;
    logic [DATA_W/8-1:0]    bus_wstrb_q;
    logic                   if_ack_q;
    logic                   if_err_q;
    logic [DATA_W-1:0]      if_rdata_q;
    logic                   mem_ack_q;
    logic                   mem_err_q;
    logic [DATA_W-1:0]      mem_rdata_q;

    logic                   grant_mem_d;
    logic                   grant_if_d;
    logic [BC_W-1:0]        burst_cnt_d;

    // Arbitration decision and the MEM-run counter update it implies
    always_comb begin
        grant_mem_d = mem_req && !(if_req && (burst_cnt_q == c_BURST_MAX));
        grant_if_d  = !grant_mem_d && if_req;
        burst_cnt_d = burst_cnt_q;
        if (grant_mem_d) begin
            if (!if_req) begin
                burst_cnt_d = '0;
            end else if (burst_cnt_q != c_BURST_MAX) begin
                burst_cnt_d = burst_cnt_q + BC_W'(1);
            end
        end else if (grant_if_d) begin
            burst_cnt_d = '0;
        end
    end

    // Transaction sequencer: grant, wait for bus completion or timeout, respond
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            to_cnt_q    <= '0;
            busy_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            mem_ack_q   <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    burst_cnt_q <= burst_cnt_d;
                    if (grant_mem_d) begin
                        state_q     <= BUS_MEM;
                        busy_q      <= 1'b1;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_we;
                        bus_addr_q  <= mem_addr;
                        bus_wdata_q <= mem_wdata;
                        bus_wstrb_q <= mem_wstrb;
                        to_cnt_q    <= '0;
                    end else if (grant_if_d) begin
                        state_q     <= BUS_IF;
                        busy_q      <= 1'b1;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= if_addr;
                        bus_wdata_q <= '0;
                        bus_wstrb_q <= '0;
                        to_cnt_q    <= '0;
                    end
                end
                BUS_IF, BUS_MEM: begin
                    // bus_ack takes precedence over a timeout in the same cycle
                    if (bus_ack || (to_cnt_q == c_TO_LAST)) begin
                        state_q   <= RESP;
                        bus_req_q <= 1'b0;
                        if (state_q == BUS_IF) begin
                            if_ack_q   <= 1'b1;
                            if_err_q   <= !bus_ack;
                            if_rdata_q <= bus_ack ? bus_rdata : '0;
                        end else begin
                            mem_ack_q   <= 1'b1;
                            mem_err_q   <= !bus_ack;
                            mem_rdata_q <= (bus_ack && !bus_we_q) ? bus_rdata : '0;
                        end
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
                end
                RESP: begin
                    // requests are deliberately ignored here; the requester
                    // updates its req on the edge that ends this cycle
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    if_ack_q  <= 1'b0;
                    mem_ack_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;
    assign if_ack    = if_ack_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign mem_ack   = mem_ack_q;
    assign mem_err   = mem_err_q;
    assign mem_rdata = mem_rdata_q;
    assign busy_o    = busy_q;
    assign stall_o   = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Randomised scoreboard bench for mem_port_arbiter. A bus
//                responder model predicts each grant from the arbitration
//                rules, checks the bus fields and queues the response each
//                requester should receive; a monitor pops and compares acks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int BMAX = 4;
    localparam int TMO  = 8;
    localparam logic [7:0] GM = 8'd77;  // 'M'
    localparam logic [7:0] GI = 8'd73;  // 'I'

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_ack, if_err;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          mem_req, mem_we, mem_ack, mem_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [SW-1:0] mem_wstrb;
    logic          bus_req, bus_we, bus_ack;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;
    logic [SW-1:0] bus_wstrb;
    logic          stall_o, busy_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_BURST_MAX(BMAX), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stall_o(stall_o), .busy_o(busy_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model state ----------------
    logic [DW:0]   if_q[$];       // {err, rdata}
    logic [DW:0]   mem_q[$];
    logic [7:0]    grants[$];
    int            mem_run = 0;   // MEM grants in a row while IF waited
    int            slave_mode = -2;  // -2 random latency, -1 never ack, >=0 fixed
    bit            use_fixed = 1'b0;
    logic [DW-1:0] fixed_data = '0;

    // request snapshot as seen by the arbiter at each rising edge
    logic          s_if_req, s_mem_req, s_mem_we;
    logic [AW-1:0] s_if_addr, s_mem_addr;
    logic [DW-1:0] s_mem_wdata;
    logic [SW-1:0] s_mem_wstrb;

    always @(posedge clk) begin
        s_if_req    <= if_req;
        s_if_addr   <= if_addr;
        s_mem_req   <= mem_req;
        s_mem_we    <= mem_we;
        s_mem_addr  <= mem_addr;
        s_mem_wdata <= mem_wdata;
        s_mem_wstrb <= mem_wstrb;
    end

    // ---------------- bus responder + grant predictor ----------------
    bit            act = 1'b0;
    bit            win_mem;
    int            lat, lat0, cyc;
    logic [DW-1:0] dat;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [SW-1:0] e_wstrb;

    initial begin
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                act = 1'b0; bus_ack = 1'b0; mem_run = 0;
                if_q.delete(); mem_q.delete();
            end else if (bus_req && !act) begin
                act = 1'b1; cyc = 1;
                check("grant_has_requester", {63'd0, s_mem_req | s_if_req}, 64'd1);
                win_mem = s_mem_req && !(s_if_req && mem_run == BMAX);
                if (win_mem) begin
                    grants.push_back(GM);
                    mem_run = s_if_req ? ((mem_run < BMAX) ? mem_run + 1 : BMAX) : 0;
                    e_we = s_mem_we; e_addr = s_mem_addr; e_wdata = s_mem_wdata; e_wstrb = s_mem_wstrb;
                end else begin
                    grants.push_back(GI);
                    mem_run = 0;
                    e_we = 1'b0; e_addr = s_if_addr; e_wdata = '0; e_wstrb = '0;
                end
                lat  = (slave_mode == -2) ? int'($urandom_range(0, 3)) : slave_mode;
                lat0 = lat;
                dat  = use_fixed ? fixed_data : DW'($urandom);
                if (win_mem) mem_q.push_back((lat < 0) ? {1'b1, {DW{1'b0}}} : (e_we ? {1'b0, {DW{1'b0}}} : {1'b0, dat}));
                else         if_q.push_back((lat < 0) ? {1'b1, {DW{1'b0}}} : {1'b0, dat});
                check("bus_we", {63'd0, bus_we}, {63'd0, e_we});
                check("bus_addr", {32'd0, bus_addr}, {32'd0, e_addr});
                check("bus_wstrb", {60'd0, bus_wstrb}, {60'd0, e_wstrb});
                if (win_mem) check("bus_wdata", {32'd0, bus_wdata}, {32'd0, e_wdata});
                if (lat == 0) begin bus_ack = 1'b1; bus_rdata = dat; end
                else begin bus_ack = 1'b0; bus_rdata = DW'($urandom); end
            end else if (bus_req && act) begin
                cyc++;
                check("bus_we_stable", {63'd0, bus_we}, {63'd0, e_we});
                check("bus_addr_stable", {32'd0, bus_addr}, {32'd0, e_addr});
                check("bus_wstrb_stable", {60'd0, bus_wstrb}, {60'd0, e_wstrb});
                if (win_mem) check("bus_wdata_stable", {32'd0, bus_wdata}, {32'd0, e_wdata});
                if (lat > 0) begin
                    lat--;
                    if (lat == 0) begin bus_ack = 1'b1; bus_rdata = dat; end
                    else bus_rdata = DW'($urandom);
                end
            end else if (!bus_req && act) begin
                act = 1'b0;
                check("bus_cycles", 64'(cyc), 64'((lat0 < 0) ? TMO : lat0 + 1));
                check("ack_latency", {63'd0, win_mem ? mem_ack : if_ack}, 64'd1);
                bus_ack = 1'($urandom_range(0, 1)); bus_rdata = DW'($urandom);
            end else begin
                bus_ack = 1'($urandom_range(0, 1)); bus_rdata = DW'($urandom);
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            check("stall", {63'd0, stall_o}, {63'd0, (if_req & ~if_ack) | (mem_req & ~mem_ack)});
            check("busy", {63'd0, busy_o}, {63'd0, bus_req | if_ack | mem_ack});
            check("ack_exclusive", {63'd0, if_ack & mem_ack}, 64'd0);
            if (if_ack) begin
                if (if_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL if_ack_unexpected: got ack=1 expected no ack at %0t", $time);
                end else begin
                    e = if_q.pop_front();
                    check("if_resp", 64'({if_err, if_rdata}), 64'(e));
                end
            end
            if (mem_ack) begin
                if (mem_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL mem_ack_unexpected: got ack=1 expected no ack at %0t", $time);
                end else begin
                    e = mem_q.pop_front();
                    check("mem_resp", 64'({mem_err, mem_rdata}), 64'(e));
                end
            end
        end
    end

    // ---------------- requester tasks (called at posedge+1) ----------------
    task automatic if_txn(input logic [AW-1:0] a, output logic err, output logic [DW-1:0] rd);
        bit got = 1'b0;
        if_req = 1'b1; if_addr = a;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            got = if_ack;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL if_ack_wait: got no ack expected ack within 200 cycles");
        end
        err = if_err; rd = if_rdata;
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic mem_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [SW-1:0] ws, output logic err, output logic [DW-1:0] rd);
        bit got = 1'b0;
        mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            got = mem_ack;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL mem_ack_wait: got no ack expected ack within 200 cycles");
        end
        err = mem_err; rd = mem_rdata;
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    task automatic gap(input int g);
        if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed + random sequence ----------------
    logic          te;
    logic [DW-1:0] tr;
    logic [7:0]    exp_order[6];

    initial begin
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({bus_req, bus_we, bus_wstrb, if_ack, if_err, mem_ack, mem_err, busy_o}), 64'd0);
        check("reset_addr", 64'({bus_addr, bus_wdata}), 64'd0);
        check("reset_rdata", 64'({if_rdata, mem_rdata}), 64'd0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // single fetch, immediate bus ack
        slave_mode = 0; use_fixed = 1'b1; fixed_data = 32'h0000_0013;
        if_txn(32'h0000_0100, te, tr);
        check("fetch_rdata", 64'(tr), 64'h13);
        check("fetch_err", 64'(te), 64'd0);
        use_fixed = 1'b0; slave_mode = -2;

        // contention: MEM first, then IF
        grants.delete();
        fork
            begin
                logic e1; logic [DW-1:0] r1;
                mem_txn(1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 4'hF, e1, r1);
                check("contention_wr_rdata", 64'(r1), 64'd0);
            end
            begin
                logic e2; logic [DW-1:0] r2;
                if_txn(32'h0000_0200, e2, r2);
            end
        join
        check("contention_first", 64'(grants[0]), 64'(GM));
        check("contention_second", 64'(grants[1]), 64'(GI));

        // starvation: IF forced in after BMAX consecutive MEM grants
        grants.delete();
        fork
            begin
                logic e3; logic [DW-1:0] r3;
                for (int i = 0; i < 6; i++)
                    mem_txn(1'($urandom_range(0, 1)), 32'h3000_0000 + 32'(i * 4), DW'($urandom), SW'($urandom), e3, r3);
            end
            begin
                logic e4; logic [DW-1:0] r4;
                if_txn(32'h0000_0400, e4, r4);
            end
        join
        exp_order = '{GM, GM, GM, GM, GI, GM};
        check("starve_count", 64'(grants.size()), 64'd7);
        for (int i = 0; i < 6; i++) check("starve_order", 64'(grants[i]), 64'(exp_order[i]));

        // randomised traffic on both ports
        fork
            begin
                logic e5; logic [DW-1:0] r5;
                for (int i = 0; i < 20; i++) begin
                    if_txn({1'b0, 31'($urandom)}, e5, r5);
                    gap($urandom_range(0, 3));
                end
            end
            begin
                logic e6; logic [DW-1:0] r6;
                for (int i = 0; i < 20; i++) begin
                    mem_txn(1'($urandom_range(0, 1)), {1'b1, 31'($urandom)}, DW'($urandom), SW'($urandom), e6, r6);
                    gap($urandom_range(0, 3));
                end
            end
        join

        // timeout on a MEM read, then a normal request
        slave_mode = -1;
        mem_txn(1'b0, 32'h4000_0010, '0, '0, te, tr);
        check("timeout_err", 64'(te), 64'd1);
        check("timeout_rdata", 64'(tr), 64'd0);
        slave_mode = -2;
        if_txn(32'h0000_0800, te, tr);
        check("after_timeout_err", 64'(te), 64'd0);

        // asynchronous reset in the middle of a MEM transaction
        slave_mode = -1;
        begin
            bit seen = 1'b0;
            mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h5000_0000;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                seen = bus_req;
            end
            check("rst_mid_granted", {63'd0, seen}, 64'd1);
        end
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("rst_mid_ctrl", 64'({bus_req, bus_we, bus_wstrb, if_ack, if_err, mem_ack, mem_err, busy_o}), 64'd0);
        check("rst_mid_addr", 64'({bus_addr, bus_wdata}), 64'd0);
        check("rst_mid_rdata", 64'({if_rdata, mem_rdata}), 64'd0);
        mem_req = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        slave_mode = -2;
        if_txn(32'h0000_0C00, te, tr);
        check("after_reset_err", 64'(te), 64'd0);

        repeat (5) @(posedge clk);
        check("queues_drained", 64'(if_q.size() + mem_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
